sfp_norm: RTL and testbench

Special-function stage downstream of the psum memory: takes one row of `col` signed partial sums (one query's dot products read from pmem), accumulates the sum of their absolute values, and divides every element by that sum to produce fixed-point normalized scores for write-back to pmem. A single shared restoring divider is time-multiplexed across the columns. Valid/ready handshakes are used on both sides, so the chip controller can stall either end.

---
 rtl/sfp_norm_if.sv | 24 ++
 rtl/sfp_norm.sv | 180 ++++++++++++++++++
 tb/tb_sfp_norm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sfp_norm_if.sv
// Row in / normalized row out handshake bundle for sfp_norm.
interface sfp_norm_if #(
    parameter int unsigned bw_psum = 20,
    parameter int unsigned col     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [col*bw_psum-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [col*bw_psum-1:0]   out_data;
    logic [bw_psum+3:0]       sum_out;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sum_out, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sum_out, busy
    );
endinterface

// File: rtl/sfp_norm.sv
// L1 row normalizer: out_e = x_e * 2^frac / sum|x|, one shared restoring divider.
// Optional SFP_ROUND_EN: one extra quotient bit and round-half-up on magnitude.
module sfp_norm #(
    parameter int unsigned bw_psum = 20,
    parameter int unsigned col     = 8,
    parameter int unsigned frac    = 8
) (
    input  logic       clk,
    input  logic       reset,
    sfp_norm_if.slave  bus
);
`ifdef SFP_ROUND_EN
    localparam int unsigned Q = frac + 2;
`else
    localparam int unsigned Q = frac + 1;
`endif
    localparam int unsigned AW = bw_psum + 1;
    localparam int unsigned SW = bw_psum + 4;
    localparam int unsigned RW = bw_psum + 5;
    localparam int unsigned MW = frac + 1;
    localparam int unsigned EW = (col > 1) ? $clog2(col) : 1;
    localparam int unsigned KW = $clog2(Q + 1);
    localparam int unsigned DW = col * bw_psum;

    typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     row_q, row_d;
    logic [AW-1:0]     abs_q [col];
    logic [AW-1:0]     abs_d [col];
    logic [col-1:0]    neg_q, neg_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [Q-1:0]      quo_q, quo_d;
    logic [EW-1:0]     elem_q, elem_d;
    logic [KW-1:0]     bit_q, bit_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [AW-1:0]     abs_c [col];
    logic [col-1:0]    neg_c;
    logic [SW-1:0]     sum_c;
    logic [AW-1:0]     cur_abs_c;
    logic [RW-1:0]     rem_sh_c, rem_nx_c;
    logic [Q-1:0]      quo_nx_c;
    logic              fits_c, zero_c, last_bit_c, last_elem_c;
    logic [MW-1:0]     mag_c;
    logic [bw_psum-1:0] lane_pos_c, lane_c;
`ifdef SFP_ROUND_EN
    logic [Q:0]        rnd_c;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            abs_q       <= '{default: '0};
            neg_q       <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            elem_q      <= '0;
            bit_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            abs_q       <= abs_d;
            neg_q       <= neg_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            elem_q      <= elem_d;
            bit_q       <= bit_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Magnitudes are one bit wider so the most negative psum is exact.
    always_comb begin
        abs_c = '{default: '0};
        neg_c = '0;
        sum_c = '0;
        for (int e = 0; e < col; e++) begin
            neg_c[e] = row_q[e*bw_psum + bw_psum - 1];
            abs_c[e] = neg_c[e] ? AW'(-{1'b1, row_q[e*bw_psum +: bw_psum]})
                                : {1'b0, row_q[e*bw_psum +: bw_psum]};
            sum_c    = sum_c + SW'(abs_c[e]);
        end
    end

    // First step shifts in the whole magnitude; later steps shift in zeros.
    always_comb begin
        cur_abs_c   = abs_q[elem_q];
        rem_sh_c    = (bit_q == '0) ? RW'(cur_abs_c) : (rem_q << 1);
        fits_c      = (rem_sh_c >= RW'(sum_q));
        rem_nx_c    = fits_c ? (rem_sh_c - RW'(sum_q)) : rem_sh_c;
        quo_nx_c    = (quo_q << 1) | Q'(fits_c);
        zero_c      = (sum_q == '0);
        last_bit_c  = (bit_q == KW'(Q - 1));
        last_elem_c = (elem_q == EW'(col - 1));
`ifdef SFP_ROUND_EN
        rnd_c       = (Q+1)'(quo_nx_c) + (Q+1)'(1);
        mag_c       = MW'(rnd_c >> 1);
`else
        mag_c       = MW'(quo_nx_c);
`endif
        lane_pos_c  = bw_psum'(mag_c);
        lane_c      = neg_q[elem_q] ? -lane_pos_c : lane_pos_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SUM;
            SUM:     state_d = DIV;
            DIV:     if (zero_c || (last_bit_c && last_elem_c)) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d       = row_q;
        abs_d       = abs_q;
        neg_d       = neg_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        elem_d      = elem_q;
        bit_d       = bit_q;
        out_data_d  = out_data_q;
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);
        case (state_q)
            IDLE: if (bus.in_valid) row_d = bus.in_data;
            SUM: begin
                abs_d  = abs_c;
                neg_d  = neg_c;
                sum_d  = sum_c;
                rem_d  = '0;
                quo_d  = '0;
                elem_d = '0;
                bit_d  = '0;
            end
            DIV: begin
                if (zero_c) begin
                    out_data_d = '0;
                end else if (last_bit_c) begin
                    for (int e = 0; e < col; e++)
                        if (EW'(e) == elem_q) out_data_d[e*bw_psum +: bw_psum] = lane_c;
                    rem_d  = '0;
                    quo_d  = '0;
                    bit_d  = '0;
                    elem_d = elem_q + EW'(1);
                end else begin
                    rem_d = rem_nx_c;
                    quo_d = quo_nx_c;
                    bit_d = bit_q + KW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sum_out   = sum_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm: directed rows with hand-computed normalized lanes.
`timescale 1ns/1ps
module tb_sfp_norm;
    localparam int unsigned BW  = 20;
    localparam int unsigned COL = 8;
    localparam int unsigned DW  = BW * COL;
    localparam int unsigned SW  = BW + 4;
`ifdef SFP_ROUND_EN
    localparam int LAT = 81;
    localparam int L21 = 171;
`else
    localparam int LAT = 73;
    localparam int L21 = 170;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] sum;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sfp_norm_if #(.bw_psum(BW), .col(COL)) bus ();
    sfp_norm #(.bw_psum(BW), .col(COL), .frac(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
        logic [DW-1:0] r;
        int v[8];
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        v[4] = l4; v[5] = l5; v[6] = l6; v[7] = l7;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*BW +: BW] = BW'(v[i]);
        return r;
    endfunction

    task automatic push(input string name, input logic [DW-1:0] data, input int sum);
        exp_t e;
        e.name = name;
        e.data = data;
        e.sum  = SW'(sum);
        sb.push_back(e);
    endtask

    task automatic accept(input logic [DW-1:0] row);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", DW'(bus.in_ready), DW'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = row;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n = 0;
        while (!bus.out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, DW'(n), DW'(lat));
    endtask

    task automatic run(input string name, input logic [DW-1:0] row, input logic [DW-1:0] exp,
                       input int sum, input int lat);
        accept(row);
        push(name, exp, sum);
        wait_valid(name, lat);
    endtask

    // Monitor: every output handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", DW'(sb.size()), DW'(1));
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_data"}, bus.out_data, mon_e.data);
                chk({mon_e.name, "_sum"}, DW'(bus.sum_out), DW'(mon_e.sum));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] ones_row, ones_exp, big_exp;
        int n;
        ones_row = pk(1, 1, 1, 1, 1, 1, 1, 1);
        ones_exp = pk(32, 32, 32, 32, 32, 32, 32, 32);
        big_exp  = pk(-256, 0, 0, 0, 0, 0, 0, 0);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  DW'(bus.in_ready),  DW'(1));
        chk("rst_busy",      DW'(bus.busy),      DW'(0));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_data",  bus.out_data,       '0);
        chk("rst_sum_out",   DW'(bus.sum_out),   DW'(0));
        @(negedge clk);
        reset = 1'b1;

        run("ones", ones_row, ones_exp, 8, LAT);
        run("pm100", pk(100, -100, 0, 0, 0, 0, 0, 0), pk(128, -128, 0, 0, 0, 0, 0, 0), 200, LAT);
        run("two_one", pk(2, 1, 0, 0, 0, 0, 0, 0), pk(L21, 85, 0, 0, 0, 0, 0, 0), 3, LAT);
        run("zero", '0, '0, 0, 2);

        // Most negative psum with the consumer stalling for five cycles.
        accept(pk(-524288, 0, 0, 0, 0, 0, 0, 0));
        bus.out_ready = 1'b0;
        push("minneg", big_exp, 524288);
        wait_valid("minneg", LAT);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ones_row;
            @(posedge clk);
            #1;
            chk("stall_out_valid", DW'(bus.out_valid), DW'(1));
            chk("stall_out_data",  bus.out_data,       big_exp);
            chk("stall_sum_out",   DW'(bus.sum_out),   DW'(524288));
            chk("stall_in_ready",  DW'(bus.in_ready),  DW'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", DW'(bus.in_ready), DW'(1));
        chk("post_hs_busy",     DW'(bus.busy),     DW'(0));
        push("ones_after_hold", ones_exp, 8);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("next_row_busy", DW'(bus.busy), DW'(1));
        wait_valid("ones_after_hold", LAT);

        // Reset in the middle of the divide discards the row.
        accept(ones_row);
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy",      DW'(bus.busy),      DW'(0));
        chk("midrst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("midrst_in_ready",  DW'(bus.in_ready),  DW'(1));
        chk("midrst_out_data",  bus.out_data,       '0);
        chk("midrst_sum_out",   DW'(bus.sum_out),   DW'(0));
        @(negedge clk);
        reset = 1'b1;
        run("ones_after_reset", ones_row, ones_exp, 8, LAT);

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_pending", DW'(sb.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
